// File: rtl/div_pkg.sv
// ============================================================================
//  Module      : div_pkg
//  Description : Shared constants and helpers for the iterative divider.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package div_pkg;

    localparam int DIV_W     = 32;
    localparam int DIV_ITERS = 32;
    localparam int CNT_W     = 6;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    // Two's complement magnitude; the most negative value maps to itself,
    // which reads correctly as an unsigned magnitude.
    function automatic logic [DIV_W-1:0] abs_val(input logic [DIV_W-1:0] v);
        return v[DIV_W-1] ? (~v + DIV_W'(1)) : v;
    endfunction

endpackage

`default_nettype wire

// File: rtl/div_step.sv
// ============================================================================
//  Module      : div_step
//  Description : One restoring-division iteration on unsigned magnitudes.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module div_step #(
    parameter int W = 32
) (
    input  logic [W:0]   rem_i,
    input  logic [W-1:0] quo_i,
    input  logic [W-1:0] divisor_i,
    output logic [W:0]   rem_o,
    output logic [W-1:0] quo_o
);

    logic [W+1:0] w_rem_sh;
    logic [W+1:0] w_trial;
    logic         w_fits;

    // The running remainder stays below the divisor, so one extra guard bit
    // above the shifted remainder is enough to read the borrow.
    assign w_rem_sh = {rem_i, quo_i[W-1]};
    assign w_trial  = w_rem_sh - {2'b00, divisor_i};
    assign w_fits   = ~w_trial[W+1];

    always_comb begin
        rem_o = w_rem_sh[W:0];
        quo_o = {quo_i[W-2:0], 1'b0};
        if (w_fits) begin
            rem_o = w_trial[W:0];
            quo_o = {quo_i[W-2:0], 1'b1};
        end
    end

endmodule

`default_nettype wire

// File: rtl/div.sv
// ============================================================================
//  Module      : div
//  Description : Iterative signed 32-bit divider, one quotient bit per cycle,
//                start / ready / exception handshake shared with the multiplier.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module div
    import div_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int ITERS = WIDTH
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    input  logic             ctrl_DIV,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY
);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sign_a_q, sign_a_d;
    logic             sign_b_q, sign_b_d;
    logic             ovf_q, ovf_d;
    logic [WIDTH:0]   rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             exc_q, exc_d;

    logic [WIDTH:0]   w_step_rem;
    logic [WIDTH-1:0] w_step_quo;
    logic             w_b_zero;
    logic             w_ovf;

    div_step #(.W(WIDTH)) u_step (
        .rem_i     (rem_q),
        .quo_i     (quo_q),
        .divisor_i (dvs_q),
        .rem_o     (w_step_rem),
        .quo_o     (w_step_quo)
    );

    assign w_b_zero = (data_operandB == '0);
    assign w_ovf    = (data_operandA == {1'b1, {(WIDTH-1){1'b0}}}) &&
                      (data_operandB == '1);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        sign_a_d = sign_a_q;
        sign_b_d = sign_b_q;
        ovf_d    = ovf_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        dvs_d    = dvs_q;
        result_d = result_q;
        exc_d    = exc_q;

        // A start preempts whatever is in flight.
        if (ctrl_DIV) begin
            sign_a_d = data_operandA[WIDTH-1];
            sign_b_d = data_operandB[WIDTH-1];
            quo_d    = abs_val(data_operandA);
            dvs_d    = abs_val(data_operandB);
            rem_d    = '0;
            cnt_d    = '0;
            ovf_d    = w_ovf;
            exc_d    = w_b_zero;
            if (w_b_zero) begin
                state_d  = S_DONE;
                result_d = '0;
            end else begin
                state_d  = S_RUN;
            end
        end else begin
            case (state_q)
                S_RUN: begin
                    rem_d = w_step_rem;
                    quo_d = w_step_quo;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(ITERS - 1)) begin
                        state_d  = S_DONE;
                        result_d = (sign_a_q ^ sign_b_q) ? (~w_step_quo + WIDTH'(1))
                                                         : w_step_quo;
                        exc_d    = ovf_q;
                    end
                end
                S_DONE:  state_d = S_IDLE;
                S_IDLE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            ovf_q    <= 1'b0;
            rem_q    <= '0;
            quo_q    <= '0;
            dvs_q    <= '0;
            result_q <= '0;
            exc_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            sign_a_q <= sign_a_d;
            sign_b_q <= sign_b_d;
            ovf_q    <= ovf_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            dvs_q    <= dvs_d;
            result_q <= result_d;
            exc_q    <= exc_d;
        end
    end

    assign data_result    = result_q;
    assign data_exception = exc_q;
    assign data_resultRDY = (state_q == S_DONE);

endmodule

`default_nettype wire

// File: tb/tb_div.sv
// ============================================================================
//  Module      : tb_div
//  Description : Self-checking bench for the iterative signed divider.
//  Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_div;

    logic        clock = 1'b0;
    logic        reset_n = 1'b1;
    logic        ctrl_DIV = 1'b0;
    logic [31:0] data_operandA = '0;
    logic [31:0] data_operandB = '0;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;

    div #(.WIDTH(32), .ITERS(32)) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .ctrl_DIV       (ctrl_DIV),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic        exc;
    } vec_t;

    typedef struct {
        logic [31:0] q;
        logic        exc;
        int          lat;
        int          t0;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_vec = 0;
    int   n_bad = 0;
    int   cyc   = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, req, $time);
        end
    endtask

    function automatic logic [32:0] model(input logic [31:0] a, input logic [31:0] b);
        if (b == 32'd0) return {1'b1, 32'd0};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {1'b1, 32'h8000_0000};
        return {1'b0, 32'($signed(a) / $signed(b))};
    endfunction

    // Result monitor: every RDY pulse must match the oldest outstanding start.
    always @(posedge clock) begin
        #1;
        if (data_resultRDY === 1'b1) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL spurious_rdy: got result %h exc %b, expected no RDY", data_result, data_exception);
            end else begin
                mon_e = sb.pop_front();
                chk("result", data_result, mon_e.q);
                chk("exception", {31'd0, data_exception}, {31'd0, mon_e.exc});
                chk("latency", 32'(cyc - mon_e.t0), 32'(mon_e.lat));
            end
        end else if (data_resultRDY !== 1'b0) begin
            n_vec++;
            n_bad++;
            $display("FAIL rdy_unknown: got %b, expected 0 or 1", data_resultRDY);
        end
    end

    // Expectation is queued before the start edge so a same-cycle RDY finds it.
    task automatic start_div(input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] q, input logic exc, input bit track);
        @(negedge clock);
        data_operandA = a;
        data_operandB = b;
        ctrl_DIV      = 1'b1;
        if (track) sb.push_back('{q: q, exc: exc, lat: (b == 32'd0) ? 0 : 32, t0: cyc + 1});
        @(posedge clock);
        #1;
        ctrl_DIV      = 1'b0;
        data_operandA = $urandom();
        data_operandB = $urandom();
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(posedge clock);
            #2;
            n++;
        end
        if (sb.size() != 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL timeout: got %0d results pending, expected 0", sb.size());
            sb.delete();
        end
    endtask

    initial begin
        #400000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1, "tb_div timeout");
    end

    vec_t tbl[18];

    initial begin
        logic [32:0] m;
        logic [31:0] ra, rb;

        tbl[0]  = '{32'd100,        32'd7,          32'd14,         1'b0};
        tbl[1]  = '{32'hFFFF_FF9C,  32'd7,          32'hFFFF_FFF2,  1'b0};
        tbl[2]  = '{32'd100,        32'hFFFF_FFF9,  32'hFFFF_FFF2,  1'b0};
        tbl[3]  = '{32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'd14,         1'b0};
        tbl[4]  = '{32'd5,          32'd0,          32'd0,          1'b1};
        tbl[5]  = '{32'd6,          32'd3,          32'd2,          1'b0};
        tbl[6]  = '{32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1'b1};
        tbl[7]  = '{32'h8000_0000,  32'd1,          32'h8000_0000,  1'b0};
        tbl[8]  = '{32'd7,          32'd100,        32'd0,          1'b0};
        tbl[9]  = '{32'h7FFF_FFFF,  32'h8000_0000,  32'd0,          1'b0};
        tbl[10] = '{32'h8000_0000,  32'h8000_0000,  32'd1,          1'b0};
        tbl[11] = '{32'h8000_0000,  32'd2,          32'hC000_0000,  1'b0};
        tbl[12] = '{32'd123456789,  32'hFFFF_FC18,  32'hFFFE_1DC0,  1'b0};
        tbl[13] = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd1,          1'b0};
        tbl[14] = '{32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  1'b0};
        tbl[15] = '{32'h7FFF_FFFF,  32'd1,          32'h7FFF_FFFF,  1'b0};
        tbl[16] = '{32'd0,          32'd5,          32'd0,          1'b0};
        tbl[17] = '{32'hFFFF_FFFB,  32'd0,          32'd0,          1'b1};

        // Asynchronous reset takes effect between clock edges.
        #2 reset_n = 1'b0;
        #1;
        chk("reset_result", data_result, 32'd0);
        chk("reset_exc", {31'd0, data_exception}, 32'd0);
        chk("reset_rdy", {31'd0, data_resultRDY}, 32'd0);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;

        for (int i = 0; i < 18; i++) begin
            start_div(tbl[i].a, tbl[i].b, tbl[i].q, tbl[i].exc, 1'b1);
            drain(60);
        end

        for (int i = 0; i < 12; i++) begin
            ra = $urandom();
            rb = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(1, 20)) : $urandom();
            if (i == 5) rb = 32'd0;
            m = model(ra, rb);
            start_div(ra, rb, m[31:0], m[32], 1'b1);
            drain(60);
        end

        // Restart mid-RUN: only the second division may report.
        start_div(32'd1000, 32'd10, 32'd0, 1'b0, 1'b0);
        repeat (10) @(posedge clock);
        start_div(32'd9, 32'd2, 32'd4, 1'b0, 1'b1);
        drain(60);
        for (int i = 0; i < 5; i++) begin
            @(posedge clock);
            #2;
            chk("hold_result", data_result, 32'd4);
            chk("hold_rdy", {31'd0, data_resultRDY}, 32'd0);
        end

        // Abort by reset in the middle of RUN.
        start_div(32'd1000, 32'd10, 32'd0, 1'b0, 1'b0);
        repeat (15) @(posedge clock);
        #3 reset_n = 1'b0;
        #1;
        chk("abort_result", data_result, 32'd0);
        chk("abort_exc", {31'd0, data_exception}, 32'd0);
        chk("abort_rdy", {31'd0, data_resultRDY}, 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        repeat (40) @(posedge clock);
        start_div(32'd21, 32'd3, 32'd7, 1'b0, 1'b1);
        drain(60);
        repeat (3) @(posedge clock);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
